// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised 2R1W register file with sequential bulk-clear sweep
//
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write
// straight to a read port that addresses the same register in the same cycle.
// With the macro undefined, read ports only ever show stored contents.

module reg_file_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWE,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] Buss,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] Ra,
   output logic [DATA_W-1:0] Rb,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              wr_drop
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]   regs_q [DEPTH];
   logic [DATA_W-1:0]   regs_d [DEPTH];

   logic                r0_write;
   logic                wr_accept;

   // A write to R0 is silently swallowed when R0 is hard-wired to zero;
   // writes arriving while the sweep owns the array are rejected.
   always_comb begin
      r0_write  = (ZERO_R0 != 0) && (DR == '0);
      wr_accept = regWE && (state_q != ST_CLEAR) && !r0_write;
   end

   // Next-state logic for the clear sequencer; clr_req is only honoured in IDLE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (clr_req) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               idx_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Array update: the sweep zeroes one entry per cycle, otherwise an accepted write lands.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (state_q == ST_CLEAR) begin
         regs_d[idx_q] = '0;
      end else if (wr_accept) begin
         regs_d[DR] = Buss;
      end
   end

   // State, sweep index and storage; reset clears everything without waiting for clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read port A: stored value, R0 masking, optional same-cycle forwarding.
   always_comb begin
      Ra = regs_q[SR1];
      if ((ZERO_R0 != 0) && (SR1 == '0)) begin
         Ra = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && !reset && (DR == SR1)) begin
         Ra = Buss;
      end
`endif
   end

   // Read port B: identical rules to port A so equal addresses give equal data.
   always_comb begin
      Rb = regs_q[SR2];
      if ((ZERO_R0 != 0) && (SR2 == '0)) begin
         Rb = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_accept && !reset && (DR == SR2)) begin
         Rb = Buss;
      end
`endif
   end

   // Status flags are decoded straight from the sequencer state.
   always_comb begin
      clr_busy = (state_q == ST_CLEAR);
      clr_done = (state_q == ST_DONE);
      wr_drop  = regWE && (state_q == ST_CLEAR);
   end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        regWE = 1'b0;
   logic [2:0]  DR = '0;
   logic [15:0] Buss = '0;
   logic [2:0]  SR1 = '0;
   logic [2:0]  SR2 = '0;
   logic [15:0] Ra, Rb;
   logic        clr_req = 1'b0;
   logic        clr_busy, clr_done, wr_drop;

   logic        z_regWE = 1'b0;
   logic [2:0]  z_DR = '0;
   logic [15:0] z_Buss = '0;
   logic [2:0]  z_SR1 = '0;
   logic [2:0]  z_SR2 = '0;
   logic [15:0] z_Ra, z_Rb;
   logic        z_clr_req = 1'b0;
   logic        z_clr_busy, z_clr_done, z_wr_drop;

   int tests = 0;
   int fails = 0;

   reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) dut (
      .clk(clk), .reset(reset), .regWE(regWE), .DR(DR), .Buss(Buss),
      .SR1(SR1), .SR2(SR2), .Ra(Ra), .Rb(Rb), .clr_req(clr_req),
      .clr_busy(clr_busy), .clr_done(clr_done), .wr_drop(wr_drop)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) dut_z (
      .clk(clk), .reset(reset), .regWE(z_regWE), .DR(z_DR), .Buss(z_Buss),
      .SR1(z_SR1), .SR2(z_SR2), .Ra(z_Ra), .Rb(z_Rb), .clr_req(z_clr_req),
      .clr_busy(z_clr_busy), .clr_done(z_clr_done), .wr_drop(z_wr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: memory contents plus a sweep position
   // (-1 idle, 0..7 = register being zeroed this cycle, 8 = completion cycle).
   logic [15:0] mem [8] = '{default: 16'h0};
   int          sweep = -1;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) mem[i] <= 16'h0;
         sweep <= -1;
      end else if (sweep >= 0 && sweep < 8) begin
         mem[sweep] <= 16'h0;
         sweep <= sweep + 1;
      end else begin
         if (regWE) mem[DR] <= Buss;
         if (sweep == 8) sweep <= -1;
         else if (clr_req) sweep <= 0;
      end
   end

   function automatic logic [15:0] model_read(input logic [2:0] a);
      logic [15:0] v;
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (!reset && regWE && !(sweep >= 0 && sweep < 8) && DR == a) v = Buss;
`endif
      return v;
   endfunction

   // Every-cycle comparison of the main instance against the model.
   always @(negedge clk) begin
      chk("ra", Ra, model_read(SR1));
      chk("rb", Rb, model_read(SR2));
      chk("clr_busy", clr_busy, (sweep >= 0 && sweep < 8));
      chk("clr_done", clr_done, (sweep == 8));
      chk("wr_drop", wr_drop, regWE && (sweep >= 0 && sweep < 8));
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_all;
      for (int i = 0; i < 8; i++) begin
         regWE = 1'b1; DR = 3'(i); Buss = 16'(16'h1111 * (i + 1));
         tick();
      end
      regWE = 1'b0;
   endtask

   int busy_n, done_n;

   initial begin
      // reset state
      #2;
      chk("rst_ra", Ra, 16'h0);
      chk("rst_busy", clr_busy, 1'b0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // basic write then read
      regWE = 1'b1; DR = 3'd5; Buss = 16'h1234; SR1 = 3'd0; SR2 = 3'd0;
      tick();
      regWE = 1'b0; SR1 = 3'd5; SR2 = 3'd4;
      #1;
      chk("r5_read", Ra, 16'h1234);
      chk("r4_read", Rb, 16'h0000);
      SR2 = 3'd5;
      #1;
      chk("same_addr", Rb, Ra);
      chk("same_addr_val", Rb, 16'h1234);

      // same-cycle visibility of a write
      regWE = 1'b1; DR = 3'd3; Buss = 16'h0333;
      tick();
      Buss = 16'hBEEF; SR1 = 3'd3;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("bypass_same", Ra, 16'hBEEF);
`else
      chk("nobypass_same", Ra, 16'h0333);
`endif
      tick();
      regWE = 1'b0;
      #1;
      chk("beef_next", Ra, 16'hBEEF);

      // full sweep timing
      load_all();
      SR1 = 3'd7; SR2 = 3'd0;
      #1;
      chk("r7_loaded", Ra, 16'h8888);
      chk("r0_loaded", Rb, 16'h1111);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_n = 0; done_n = 0;
      for (int k = 0; k < 12; k++) begin
         if (clr_busy) busy_n++;
         if (clr_done) done_n++;
         tick();
      end
      chk("busy_cycles", busy_n, 8);
      chk("done_pulses", done_n, 1);
      for (int i = 0; i < 8; i++) begin
         SR1 = 3'(i); SR2 = 3'(7 - i);
         #1;
         chk("swept_a", Ra, 16'h0);
         chk("swept_b", Rb, 16'h0);
      end

      // dropped write during sweep, ignored clr_req, partial-sweep reads
      load_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick();
      regWE = 1'b1; DR = 3'd2; Buss = 16'hAAAA; SR1 = 3'd1; SR2 = 3'd6;
      #1;
      chk("drop_pulse", wr_drop, 1'b1);
      chk("swept_r1", Ra, 16'h0000);
      chk("unswept_r6", Rb, 16'h7777);
      tick();
      regWE = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      SR1 = 3'd2;
      #1;
      chk("r2_after_drop", Ra, 16'h0000);
      chk("no_restart", clr_busy, 1'b0);

      // write and clr_req together: write lands then gets swept
      regWE = 1'b1; DR = 3'd6; Buss = 16'h6666; clr_req = 1'b1; SR1 = 3'd6;
      tick();
      regWE = 1'b0; clr_req = 1'b0;
      #1;
      chk("r6_before_sweep", Ra, 16'h6666);
      for (int k = 0; k < 10; k++) tick();
      chk("r6_after_sweep", Ra, 16'h0000);

      // reset mid-sweep
      load_all();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      tick(); tick(); tick();
      SR1 = 3'd5;
      #1;
      reset = 1'b1;
      #1;
      chk("rst_busy_drop", clr_busy, 1'b0);
      chk("rst_ra_zero", Ra, 16'h0);
      tick();
      reset = 1'b0;
      done_n = 0;
      for (int k = 0; k < 12; k++) begin
         if (clr_done) done_n++;
         tick();
      end
      chk("no_done_after_rst", done_n, 0);
      for (int i = 0; i < 8; i++) begin
         SR2 = 3'(i);
         #1;
         chk("rst_all_zero", Rb, 16'h0);
      end

      // write during DONE accepted, clr_req in DONE ignored
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      chk("in_done", clr_done, 1'b1);
      regWE = 1'b1; DR = 3'd4; Buss = 16'h4444; clr_req = 1'b1;
      tick();
      regWE = 1'b0; clr_req = 1'b0; SR1 = 3'd4;
      #1;
      chk("done_write", Ra, 16'h4444);
      chk("done_req_ignored", clr_busy, 1'b0);
      tick();
      chk("still_idle", clr_busy, 1'b0);

      // hard-wired R0 instance
      z_regWE = 1'b1; z_DR = 3'd0; z_Buss = 16'hFFFF; z_SR1 = 3'd0; z_SR2 = 3'd1;
      #1;
      chk("z_r0_same", z_Ra, 16'h0);
      chk("z_drop", z_wr_drop, 1'b0);
      tick();
      z_DR = 3'd1; z_Buss = 16'h00AB;
      #1;
      chk("z_r0_after", z_Ra, 16'h0);
      tick();
      z_regWE = 1'b0;
      #1;
      chk("z_r1", z_Rb, 16'h00AB);
      chk("z_r0_final", z_Ra, 16'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_R0, default 0, when 1 register 0 reads as zero and ignores writes.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 regWE  input  1  write enable for port W.
REQ-007 DR  input  ADDR_W  write address.
REQ-008 Buss  input  DATA_W  write data.
REQ-009 SR1  input  ADDR_W  read address, port A.
REQ-010 SR2  input  ADDR_W  read address, port B.
REQ-011 Ra  output  DATA_W  read data, port A; combinational from SR1.
REQ-012 Rb  output  DATA_W  read data, port B; combinational from SR2.
REQ-013 clr_req  input  1  request bulk clear of all registers.
REQ-014 clr_busy  output  1  high while clear sweep is in progress.
REQ-015 clr_done  output  1  one-cycle pulse at sweep completion.
REQ-016 wr_drop  output  1  one-cycle pulse when a regWE write is discarded.

Function
REQ-017 In IDLE, regWE=1 SHALL write Buss to register DR at the rising edge; readable from the next cycle.
REQ-018 Ra/Rb SHALL return register SR1/SR2 contents with zero-cycle latency; SR1==SR2 SHALL give identical outputs.
REQ-019 With ZERO_R0=1, writes to DR=0 SHALL be discarded without wr_drop, and reads of address 0 SHALL return 0.
REQ-020 FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on clr_req=1; CLEAR->DONE after index DEPTH-1 is cleared; DONE->IDLE unconditionally after one cycle.
REQ-021 In CLEAR, an ADDR_W-bit index SHALL start at 0, zero one register per cycle, and increment by 1; sweep SHALL take exactly DEPTH cycles.
REQ-022 clr_busy SHALL be 1 exactly in CLEAR; clr_done SHALL be 1 exactly in DONE.
REQ-023 clr_req in CLEAR or DONE SHALL be ignored (no restart, no queuing).
REQ-024 regWE=1 in CLEAR SHALL be discarded and wr_drop pulsed in that same cycle; regWE in IDLE or DONE SHALL be accepted.
REQ-025 clr_req and regWE asserted together in IDLE: the write SHALL complete at that edge, then the sweep SHALL overwrite it with zero.
REQ-026 Reads during CLEAR SHALL return 0 for swept indices and old contents for unswept indices.

Reset
REQ-027 reset=1 SHALL immediately zero all registers, force IDLE, and zero the sweep index, independent of clk.
REQ-028 During and after reset until the next write, Ra, Rb, clr_busy, clr_done and wr_drop SHALL be 0.
REQ-029 reset asserted mid-sweep SHALL abort the sweep; no clr_done pulse SHALL follow.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when regWE=1, write accepted and DR==SR1 (or SR2), Ra (or Rb) SHALL equal Buss in the same cycle.
REQ-031 REGFILE_BYPASS_EN undefined: Ra/Rb SHALL show the stored value only; a same-cycle write SHALL be visible from the next cycle.
REQ-032 Dropped writes (REQ-024) and R0 writes with ZERO_R0=1 SHALL never bypass.

Verification (DATA_W=16, ADDR_W=3)
REQ-033 Reset, write 0x1234 to R5, SR1=5 next cycle -> Ra=0x1234; SR2=4 -> Rb=0x0000.
REQ-034 Write 0xBEEF to R3 with SR1=3 in the same cycle -> Ra=0xBEEF in that cycle with REGFILE_BYPASS_EN, old value without.
REQ-035 Load R0..R7 with 0x1111*(i+1), pulse clr_req -> clr_busy high 8 cycles, clr_done one pulse, all registers read 0x0000 afterwards.
REQ-036 regWE with DR=2, Buss=0xAAAA during CLEAR cycle 4 -> wr_drop pulse; R2 reads 0x0000 after sweep.
REQ-037 Assert reset at sweep cycle 3 -> clr_busy falls immediately, no clr_done, all registers 0x0000.
REQ-038 ZERO_R0=1, write 0xFFFF to R0 -> Ra(SR1=0)=0x0000 in the write cycle and after, wr_drop stays 0.
